// File: rtl/sequential_logical_gteq.sv
// sequential_logical_gteq: bit-serial MSB-first unsigned a >= b / a == b comparator with start/busy/done handshake.
// Define SEQUENTIAL_LOGICAL_GTEQ_EARLY_EXIT_EN to leave SCAN at the first differing bit.
module sequential_logical_gteq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         c,
    output logic         eq
);
    localparam int IW = N > 1 ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state, state_n;
    logic [N-1:0] a_q, b_q;
    logic [IW-1:0] idx;
    logic bit_a, bit_b, differ, last, finish, res_c, res_eq;
    assign bit_a  = a_q[idx];
    assign bit_b  = b_q[idx];
    assign differ = bit_a != bit_b;
    assign last   = idx == '0;
`ifdef SEQUENTIAL_LOGICAL_GTEQ_EARLY_EXIT_EN
    assign finish = differ || last;
    assign res_c  = differ ? bit_a : 1'b1;
    assign res_eq = !differ;
`else
    logic sticky, sticky_c;
    assign finish = last;
    assign res_c  = sticky ? sticky_c : (differ ? bit_a : 1'b1);
    assign res_eq = !sticky && !differ;
`endif
    assign busy = state != IDLE;
    assign done = state == DONE;
    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (start ? SCAN : IDLE) :
                  state == SCAN ? (finish ? DONE : SCAN) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            idx   <= '0;
            c     <= 1'b0;
            eq    <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                a_q <= a;
                b_q <= b;
                idx <= IW'(N - 1);
            end else if (state == SCAN) begin
                if (finish) begin
                    c  <= res_c;
                    eq <= res_eq;
                end else begin
                    idx <= idx - 1'b1;
                end
            end
        end
    end
`ifndef SEQUENTIAL_LOGICAL_GTEQ_EARLY_EXIT_EN
    // The first (most significant) mismatch decides; later bits cannot override it.
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && start)) begin
            sticky   <= 1'b0;
            sticky_c <= 1'b0;
        end else if (state == SCAN && !sticky && differ) begin
            sticky   <= 1'b1;
            sticky_c <= bit_a;
        end
    end
`endif
endmodule

// File: tb/tb_sequential_logical_gteq.sv
// tb_sequential_logical_gteq: randomized self-checking bench against an arithmetic reference model (N=8 and N=1).
module tb_sequential_logical_gteq;
    logic clk = 1'b0;
    logic rst, start, start1;
    logic [7:0] a, b;
    logic [0:0] a1, b1;
    logic busy, done, c, eq, busy1, done1, c1, eq1;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sequential_logical_gteq #(.N(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .c(c), .eq(eq)
    );
    sequential_logical_gteq #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .c(c1), .eq(eq1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int scan_len(input int w, input logic [7:0] x, input logic [7:0] y);
        int m;
        m = w;
`ifdef SEQUENTIAL_LOGICAL_GTEQ_EARLY_EXIT_EN
        for (int k = 0; k < w; k++)
            if (x[k] != y[k]) m = w - k;
`endif
        return m;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the first idle cycle after DONE.
    task automatic cmp8(input logic [7:0] x, input logic [7:0] y);
        int cyc;
        int m;
        m = scan_len(8, x, y);
        start = 1'b1;
        a = x;
        b = y;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk("busy_scan", busy, 1);
            if (!done) begin
                start = 1'($urandom);
                a = 8'($urandom);
                b = 8'($urandom);
            end
        end while (!done && cyc < 40);
        start = 1'b0;
        chk("latency", cyc, m + 1);
        chk("busy_done", busy, 1);
        chk("c", c, x >= y);
        chk("eq", eq, x == y);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("busy_idle", busy, 0);
    endtask

    task automatic cmp1(input logic x, input logic y);
        int cyc;
        start1 = 1'b1;
        a1 = x;
        b1 = y;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            start1 = 1'b0;
            a1 = ~a1;
            b1 = 1'($urandom);
        end while (!done1 && cyc < 10);
        chk("n1_latency", cyc, 2);
        chk("n1_c", c1, x >= y);
        chk("n1_eq", eq1, x == y);
        @(negedge clk);
        chk("n1_done_pulse", done1, 0);
        chk("n1_busy_idle", busy1, 0);
    endtask

    initial begin
        int seen;
        logic [7:0] x, y;
        rst = 1'b1;
        start = 1'b0;
        start1 = 1'b0;
        a = '0;
        b = '0;
        a1 = '0;
        b1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_c", c, 0);
        chk("rst_eq", eq, 0);
        rst = 1'b0;

        cmp8(8'h80, 8'h7F);
        cmp8(8'h05, 8'h06);
        repeat (5) @(negedge clk);
        chk("hold_c", c, 0);
        chk("hold_eq", eq, 0);
        cmp8(8'hA5, 8'hA5);
        cmp8(8'h00, 8'hFF);
        cmp8(8'hFF, 8'h00);
        cmp8(8'h01, 8'h01);
        cmp8(8'hFE, 8'hFF);

        for (int i = 0; i < 40; i++) begin
            x = 8'($urandom);
            y = (i % 4 == 0) ? x : (i % 4 == 1) ? (x ^ 8'(1 << $urandom_range(0, 7))) : 8'($urandom);
            cmp8(x, y);
        end

        // Reset in cycle 3 of an equal-operand scan, after a prior result left c/eq high.
        cmp8(8'h3C, 8'h3C);
        start = 1'b1;
        a = 8'hA5;
        b = 8'hA5;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_c", c, 0);
        chk("midrst_eq", eq, 0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("midrst_no_done", seen, 0);

        // Reset and start together: nothing accepted.
        rst = 1'b1;
        start = 1'b1;
        a = 8'hFF;
        b = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", busy, 0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("rst_start_idle", seen, 0);

        cmp1(1'b0, 1'b0);
        cmp1(1'b0, 1'b1);
        cmp1(1'b1, 1'b0);
        cmp1(1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
